fetch_stage: RTL and testbench

- Instruction-fetch stage of the tinycpu pipeline; sits directly upstream of the asynchronous instruction ROM.
- Owns the program counter and drives `PC` to the ROM. The ROM returns `instr` combinationally in the same cycle.
- Captures PC, PC+4 and instruction into the IF/ID pipeline register.
- Handles stall, redirect (branch/jump flush) and halt-on-EBREAK.

---
 rtl/fetch_stage.sv | 171 +++++++++++++++++
 tb/tb_fetch_stage.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the tinycpu pipeline.
// Owns the program counter, reads the asynchronous instruction ROM through PC/instr_i,
// and fills the IF/ID register. It also handles stall, redirect (branch/jump flush)
// and halt-on-EBREAK.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN. When it is defined, a redirect to a
// target that is not word-aligned traps: fetch halts and the misaligned flag is raised.
module fetch_stage #(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC     = 32'h0000_0000,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR    = 32'h0000_0013,
    parameter logic [DATA_WIDTH-1:0] EBREAK_INSTR = 32'h0010_0073
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_target_i,
    input  logic [DATA_WIDTH-1:0] instr_i,
    output logic [DATA_WIDTH-1:0] PC,
    output logic [DATA_WIDTH-1:0] ID_instr,
    output logic [DATA_WIDTH-1:0] ID_PC,
    output logic [DATA_WIDTH-1:0] ID_PCPlus4,
    output logic                  ID_valid,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic                  misaligned,
`endif
    output logic                  halted
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [DATA_WIDTH-1:0]   pc_d;
    logic [DATA_WIDTH-1:0]   id_instr_d;
    logic [DATA_WIDTH-1:0]   id_pc_d;
    logic [DATA_WIDTH-1:0]   id_pcplus4_d;
    logic                    id_valid_d;
    logic                    halted_d;
    logic [DATA_WIDTH-1:0]   pc_plus4;
    logic                    redirect_bad;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic                    misaligned_d;
`endif

    assign pc_plus4 = PC + DATA_WIDTH'(4);

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redirect_bad = (redirect_target_i[1:0] != 2'b00);
`else
    assign redirect_bad = 1'b0;
`endif

    // Next-state and next-register logic; every register holds unless a case below updates it
    always_comb begin
        state_d      = state_q;
        pc_d         = PC;
        id_instr_d   = ID_instr;
        id_pc_d      = ID_PC;
        id_pcplus4_d = ID_PCPlus4;
        id_valid_d   = ID_valid;
        halted_d     = halted;
`ifdef FETCH_MISALIGN_TRAP_EN
        misaligned_d = misaligned;
`endif
        case (state_q)
            BOOT: begin
                id_valid_d = 1'b0;
                state_d    = RUN;
                if (redirect_i) begin
                    if (redirect_bad) begin
                        id_instr_d = NOP_INSTR;
                        state_d    = HALT;
                        halted_d   = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
                        misaligned_d = 1'b1;
`endif
                    end else begin
                        pc_d = redirect_target_i;
`ifdef FETCH_MISALIGN_TRAP_EN
                        misaligned_d = 1'b0;
`endif
                    end
                end
            end
            RUN: begin
                if (redirect_i) begin
                    id_instr_d = NOP_INSTR;
                    id_valid_d = 1'b0;
                    if (redirect_bad) begin
                        state_d  = HALT;
                        halted_d = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
                        misaligned_d = 1'b1;
`endif
                    end else begin
                        pc_d = redirect_target_i;
`ifdef FETCH_MISALIGN_TRAP_EN
                        misaligned_d = 1'b0;
`endif
                    end
                end else if (!stall_i) begin
                    id_instr_d   = instr_i;
                    id_pc_d      = PC;
                    id_pcplus4_d = pc_plus4;
                    id_valid_d   = 1'b1;
                    if (instr_i == EBREAK_INSTR) begin
                        state_d = HALT;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end
            HALT: begin
                id_valid_d = 1'b0;
                if (redirect_i) begin
                    if (redirect_bad) begin
                        halted_d = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
                        misaligned_d = 1'b1;
`endif
                    end else begin
                        pc_d     = redirect_target_i;
                        halted_d = 1'b0;
                        state_d  = RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
                        misaligned_d = 1'b0;
`endif
                    end
                end else begin
                    halted_d = 1'b1;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // State, PC and IF/ID registers; reset wins over every other input
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            PC         <= RESET_PC;
            ID_instr   <= NOP_INSTR;
            ID_PC      <= '0;
            ID_PCPlus4 <= '0;
            ID_valid   <= 1'b0;
            halted     <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misaligned <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            PC         <= pc_d;
            ID_instr   <= id_instr_d;
            ID_PC      <= id_pc_d;
            ID_PCPlus4 <= id_pcplus4_d;
            ID_valid   <= id_valid_d;
            halted     <= halted_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            misaligned <= misaligned_d;
`endif
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal expectations,
// then randomized stall/redirect/reset traffic against a behavioural fetch model.
module tb_fetch_stage;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] EBRK = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_target_i;
    logic [31:0] instr_i;
    logic [31:0] PC;
    logic [31:0] ID_instr;
    logic [31:0] ID_PC;
    logic [31:0] ID_PCPlus4;
    logic        ID_valid;
    logic        halted;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misaligned;
`endif

    logic [31:0] mem [256];

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model of what the IF/ID outputs must be
    bit          m_known = 1'b0;
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_idpc;
    logic [31:0] m_idp4;
    bit          m_valid;
    bit          m_halted;
    bit          m_mis;

    fetch_stage dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall_i           (stall_i),
        .redirect_i        (redirect_i),
        .redirect_target_i (redirect_target_i),
        .instr_i           (instr_i),
        .PC                (PC),
        .ID_instr          (ID_instr),
        .ID_PC             (ID_PC),
        .ID_PCPlus4        (ID_PCPlus4),
        .ID_valid          (ID_valid),
`ifdef FETCH_MISALIGN_TRAP_EN
        .misaligned        (misaligned),
`endif
        .halted            (halted)
    );

    always #5 clk = ~clk;

    assign instr_i = mem[PC[9:2]];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit stall, input bit redir, input logic [31:0] tgt);
        rst_n             = rst;
        stall_i           = stall;
        redirect_i        = redir;
        redirect_target_i = tgt;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic fillMem(input int ebreakPct);
        logic [31:0] v;
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(0, 99) < ebreakPct) begin
                mem[i] = EBRK;
            end else begin
                do v = $urandom; while (v == EBRK);
                mem[i] = v;
            end
        end
    endtask

    function automatic bit isBadTarget(input logic [31:0] tgt);
`ifdef FETCH_MISALIGN_TRAP_EN
        return (tgt % 4) != 0;
`else
        return tgt == ~tgt;
`endif
    endfunction

    // Advance the model by one clock using the inputs seen at the rising edge.
    // Modes: 0 = boot bubble, 1 = fetching, 2 = halted.
    task automatic modelStep();
        logic [31:0] fetched;
        if (!rst_n) begin
            m_known = 1'b1; m_mode = 0; m_pc = 32'h0; m_instr = NOP;
            m_idpc = 0; m_idp4 = 0; m_valid = 0; m_halted = 0; m_mis = 0;
            return;
        end
        if (!m_known) return;
        if (m_mode == 0) begin
            m_valid = 0;
            m_mode = 1;
            if (redirect_i) begin
                if (isBadTarget(redirect_target_i)) begin
                    m_instr = NOP; m_mode = 2; m_halted = 1; m_mis = 1;
                end else begin
                    m_pc = redirect_target_i; m_mis = 0;
                end
            end
        end else if (m_mode == 1) begin
            if (redirect_i) begin
                m_instr = NOP; m_valid = 0;
                if (isBadTarget(redirect_target_i)) begin
                    m_mode = 2; m_halted = 1; m_mis = 1;
                end else begin
                    m_pc = redirect_target_i; m_mis = 0;
                end
            end else if (!stall_i) begin
                fetched = mem[m_pc[9:2]];
                m_instr = fetched; m_idpc = m_pc; m_idp4 = m_pc + 32'd4; m_valid = 1;
                if (fetched == EBRK) m_mode = 2;
                else m_pc = m_pc + 32'd4;
            end
        end else begin
            m_valid = 0;
            if (redirect_i) begin
                if (isBadTarget(redirect_target_i)) begin
                    m_halted = 1; m_mis = 1;
                end else begin
                    m_pc = redirect_target_i; m_halted = 0; m_mode = 1; m_mis = 0;
                end
            end else begin
                m_halted = 1;
            end
        end
    endtask

    // Model update on each rising edge, full output comparison on each falling edge
    initial begin
        forever begin
            @(posedge clk);
            modelStep();
            @(negedge clk);
            if (m_known) begin
                checkOutput("model_pc", PC, m_pc);
                checkOutput("model_valid", {31'b0, ID_valid}, {31'b0, m_valid});
                checkOutput("model_halted", {31'b0, halted}, {31'b0, m_halted});
                checkOutput("model_instr", ID_instr, m_instr);
                if (m_valid) begin
                    checkOutput("model_id_pc", ID_PC, m_idpc);
                    checkOutput("model_id_pcplus4", ID_PCPlus4, m_idp4);
                end
`ifdef FETCH_MISALIGN_TRAP_EN
                checkOutput("model_misaligned", {31'b0, misaligned}, {31'b0, m_mis});
`endif
            end
        end
    end

    task automatic waitPc(input logic [31:0] target, input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            if (PC === target) found = 1'b1;
            else tick();
        end
        if (!found) checkOutput("wait_pc_timeout", PC, target);
    endtask

    task automatic waitEbreak(input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            if (ID_valid === 1'b1 && ID_instr === EBRK) found = 1'b1;
            else tick();
        end
        if (!found) checkOutput("wait_ebreak_timeout", ID_instr, EBRK);
    endtask

    // Directed scenarios followed by randomized traffic
    initial begin
        logic [31:0] tgt;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        fillMem(0);

        tick();
        checkOutput("reset_pc", PC, 32'h0);
        checkOutput("reset_valid", {31'b0, ID_valid}, 32'h0);
        checkOutput("reset_instr", ID_instr, NOP);
        checkOutput("reset_id_pc", ID_PC, 32'h0);
        checkOutput("reset_id_pcplus4", ID_PCPlus4, 32'h0);
        checkOutput("reset_halted", {31'b0, halted}, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("boot_pc", PC, 32'h0);
        checkOutput("boot_valid", {31'b0, ID_valid}, 32'h0);
        tick();
        checkOutput("first_instr", ID_instr, mem[0]);
        checkOutput("first_id_pc", ID_PC, 32'h0);
        checkOutput("first_id_pcplus4", ID_PCPlus4, 32'h4);
        checkOutput("first_valid", {31'b0, ID_valid}, 32'h1);
        tick();
        checkOutput("second_pc", PC, 32'h8);

        waitPc(32'h10, 10);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        tick(); tick(); tick();
        checkOutput("stall_pc", PC, 32'h10);
        checkOutput("stall_id_pc", ID_PC, 32'hC);
        checkOutput("stall_instr", ID_instr, mem[3]);
        checkOutput("stall_valid", {31'b0, ID_valid}, 32'h1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("unstall_id_pc", ID_PC, 32'h10);
        checkOutput("unstall_pc", PC, 32'h14);

        waitPc(32'h20, 10);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h100);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("redir_pc", PC, 32'h100);
        checkOutput("redir_valid", {31'b0, ID_valid}, 32'h0);
        checkOutput("redir_instr", ID_instr, NOP);
        tick();
        checkOutput("redir_id_pc", ID_PC, 32'h100);
        checkOutput("redir_id_pcplus4", ID_PCPlus4, 32'h104);

        mem[3] = EBRK;
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        waitEbreak(10);
        checkOutput("ebreak_valid", {31'b0, ID_valid}, 32'h1);
        checkOutput("ebreak_id_pc", ID_PC, 32'hC);
        checkOutput("ebreak_pc", PC, 32'hC);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        checkOutput("halt_flag", {31'b0, halted}, 32'h1);
        checkOutput("halt_valid", {31'b0, ID_valid}, 32'h0);
        checkOutput("halt_pc", PC, 32'hC);
        tick();
        checkOutput("halt_hold_pc", PC, 32'hC);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h40);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("unhalt_flag", {31'b0, halted}, 32'h0);
        checkOutput("unhalt_pc", PC, 32'h40);
        mem[3] = 32'h0000_0033;

        applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("wrap_target_pc", PC, 32'hFFFF_FFFC);
        tick();
        checkOutput("wrap_pc", PC, 32'h0);
        checkOutput("wrap_id_pc", ID_PC, 32'hFFFF_FFFC);
        checkOutput("wrap_id_pcplus4", ID_PCPlus4, 32'h0);

`ifdef FETCH_MISALIGN_TRAP_EN
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h102);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("trap_misaligned", {31'b0, misaligned}, 32'h1);
        checkOutput("trap_halted", {31'b0, halted}, 32'h1);
        checkOutput("trap_pc", PC, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h104);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("untrap_misaligned", {31'b0, misaligned}, 32'h0);
        checkOutput("untrap_halted", {31'b0, halted}, 32'h0);
        checkOutput("untrap_pc", PC, 32'h104);
`endif

        fillMem(4);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 15) == 0) tgt = $urandom;
            else tgt = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            if ($urandom_range(0, 7) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            applyStimulus($urandom_range(0, 99) != 0, $urandom_range(0, 99) < 30,
                          $urandom_range(0, 99) < 10, tgt);
            tick();
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
